// File: rtl/wptr_full_gen_if.sv
// Write-side pointer bundle of an async FIFO: write request, foreign Gray read pointer, and write status.
// Latency: none; this interface only carries the signals between modules.
// Backpressure: wfull tells the writer to stop. The block drops writes while full and records them in woverflow.
// Ports: winc, rptr_gray (from the writer / read domain); waddr, wptr_gray, wfull, wlevel, woverflow (from the pointer block).
interface wptr_full_gen_if #(
  parameter int ADDR_WIDTH = 5
);
  localparam int PTR_WIDTH = ADDR_WIDTH + 1;

  logic                  winc;
  logic [PTR_WIDTH-1:0]  rptr_gray;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [PTR_WIDTH-1:0]  wptr_gray;
  logic                  wfull;
  logic [PTR_WIDTH-1:0]  wlevel;
  logic                  woverflow;

  // The writer / read-domain side drives the request and the foreign pointer.
  modport master (
    output winc, rptr_gray,
    input  waddr, wptr_gray, wfull, wlevel, woverflow
  );

  // The pointer block consumes the request and reports status.
  modport slave (
    input  winc, rptr_gray,
    output waddr, wptr_gray, wfull, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full_gen.sv
// Async FIFO write-pointer / full-flag generator: binary and Gray write pointers, 2-flop read-pointer sync, level.
// Latency: pointer, full, and level are registered 1 edge after winc. A read-pointer change is visible by the 3rd wclk edge.
// Backpressure: while wfull=1, winc is ignored and the attempt sets the sticky woverflow flag.
// Ports: wclk, wrst (async, active-high); wif.slave carries winc, rptr_gray, waddr, wptr_gray, wfull, wlevel, woverflow.
module wptr_full_gen #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic            wclk,
  input  logic            wrst,
  wptr_full_gen_if.slave  wif
);
  localparam int PTR_WIDTH = ADDR_WIDTH + 1;

  logic [PTR_WIDTH-1:0] wbin;
  logic [PTR_WIDTH-1:0] wbin_next;
  logic [PTR_WIDTH-1:0] wgray_next;
  logic [PTR_WIDTH-1:0] wptr_gray_q;
  logic [PTR_WIDTH-1:0] rq1;
  logic [PTR_WIDTH-1:0] rq2;
  logic [PTR_WIDTH-1:0] rbin_s;
  logic [PTR_WIDTH-1:0] full_cmp;
  logic [PTR_WIDTH-1:0] wlevel_q;
  logic                 wfull_q;
  logic                 woverflow_q;
  logic                 accept;

  assign accept     = wif.winc & ~wfull_q;
  assign wbin_next  = wbin + {{(PTR_WIDTH-1){1'b0}}, accept};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // The FIFO is full when the write pointer is exactly one lap ahead of the read pointer.
  // In Gray code, that is the read pointer with its two MSBs inverted.
  assign full_cmp = {~rq2[PTR_WIDTH-1:PTR_WIDTH-2], rq2[PTR_WIDTH-3:0]};

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      rbin_s[i] = ^(rq2 >> i);
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin        <= '0;
      wptr_gray_q <= '0;
      rq1         <= '0;
      rq2         <= '0;
      wfull_q     <= 1'b0;
      wlevel_q    <= '0;
      woverflow_q <= 1'b0;
    end else begin
      // Only rq2 feeds logic; rq1 may be metastable.
      rq1         <= wif.rptr_gray;
      rq2         <= rq1;
      wbin        <= wbin_next;
      wptr_gray_q <= wgray_next;
      // Both flags use the stale synchronized read pointer.
      // As a result, full can only linger, never release early.
      wfull_q     <= (wgray_next == full_cmp);
      wlevel_q    <= wbin_next - rbin_s;
      if (wif.winc & wfull_q) begin
        woverflow_q <= 1'b1;
      end
    end
  end

  assign wif.waddr     = wbin[ADDR_WIDTH-1:0];
  assign wif.wptr_gray = wptr_gray_q;
  assign wif.wfull     = wfull_q;
  assign wif.wlevel    = wlevel_q;
  assign wif.woverflow = woverflow_q;
endmodule
